// File: rtl/opstage_pkg.sv
// rtl/opstage_pkg.sv - shared encodings and default widths for the operand stage
package opstage_pkg;

    localparam int XLEN  = 32;
    localparam int IMM_W = 20;
    localparam int OFF_W = 15;
    localparam int JMP_W = 25;
    localparam int RA_W  = 5;

    typedef enum logic [1:0] {
        SRC_REG = 2'd0,
        SRC_IMM = 2'd1,
        SRC_OFF = 2'd2,
        SRC_JMP = 2'd3
    } src_sel_e;

endpackage

// File: rtl/operand_stage_if.sv
// rtl/operand_stage_if.sv - ID/MEM/WB/ALU-side signal bundle of the operand stage
interface operand_stage_if #(
    parameter int XLEN  = opstage_pkg::XLEN,
    parameter int IMM_W = opstage_pkg::IMM_W,
    parameter int OFF_W = opstage_pkg::OFF_W,
    parameter int JMP_W = opstage_pkg::JMP_W,
    parameter int RA_W  = opstage_pkg::RA_W
) ();

    // ID side
    logic             in_valid;
    logic             in_ready;
    logic [RA_W-1:0]  rs1_addr;
    logic [RA_W-1:0]  rs2_addr;
    logic [XLEN-1:0]  read_data1;
    logic [XLEN-1:0]  read_data2;
    logic [1:0]       src_sel;
    logic             use_rs2;
    logic             zext;
    logic [IMM_W-1:0] immediate;
    logic [OFF_W-1:0] imm_addr;
    logic [JMP_W-1:0] jump_off;

    // MEM and WB stage write-back info
    logic             mem_wr_en;
    logic             mem_is_load;
    logic [RA_W-1:0]  mem_wr_addr;
    logic [XLEN-1:0]  mem_wr_data;
    logic             wb_wr_en;
    logic [RA_W-1:0]  wb_wr_addr;
    logic [XLEN-1:0]  wb_wr_data;

    // ALU side
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  input1;
    logic [XLEN-1:0]  input2;
    logic [XLEN-1:0]  store_data;
    logic             hazard;

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, read_data1, read_data2,
               src_sel, use_rs2, zext, immediate, imm_addr, jump_off,
               mem_wr_en, mem_is_load, mem_wr_addr, mem_wr_data,
               wb_wr_en, wb_wr_addr, wb_wr_data, out_ready,
        output in_ready, out_valid, input1, input2, store_data, hazard
    );

    modport master (
        output in_valid, rs1_addr, rs2_addr, read_data1, read_data2,
               src_sel, use_rs2, zext, immediate, imm_addr, jump_off,
               mem_wr_en, mem_is_load, mem_wr_addr, mem_wr_data,
               wb_wr_en, wb_wr_addr, wb_wr_data, out_ready,
        input  in_ready, out_valid, input1, input2, store_data, hazard
    );

endinterface

// File: rtl/operand_extend.sv
// rtl/operand_extend.sv - zero/sign extension of an instruction field to XLEN
module operand_extend #(
    parameter int IN_W = 20,
    parameter int XLEN = 32
) (
    input  logic [IN_W-1:0] field,
    input  logic            zext,
    output logic [XLEN-1:0] value
);

    // Fill the upper bits with zeros or with copies of the field MSB
    always_comb begin
        value = zext ? {{(XLEN-IN_W){1'b0}}, field}
                     : {{(XLEN-IN_W){field[IN_W-1]}}, field};
    end

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - registered ID->EX operand selection with forwarding (OPSTAGE_FWD_EN)
module operand_stage
    import opstage_pkg::*;
#(
    parameter int XLEN  = opstage_pkg::XLEN,
    parameter int IMM_W = opstage_pkg::IMM_W,
    parameter int OFF_W = opstage_pkg::OFF_W,
    parameter int JMP_W = opstage_pkg::JMP_W,
    parameter int RA_W  = opstage_pkg::RA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_stage_if.slave  bus
);

    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] off_ext;
    logic [XLEN-1:0] jmp_ext;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op2_val;
    logic            hazard;
    logic            in_ready;
    logic            transfer;

    logic            out_valid_q;
    logic [XLEN-1:0] input1_q;
    logic [XLEN-1:0] input2_q;
    logic [XLEN-1:0] store_data_q;

    operand_extend #(.IN_W(IMM_W), .XLEN(XLEN)) u_ext_imm (
        .field (bus.immediate),
        .zext  (bus.zext),
        .value (imm_ext)
    );

    operand_extend #(.IN_W(OFF_W), .XLEN(XLEN)) u_ext_off (
        .field (bus.imm_addr),
        .zext  (bus.zext),
        .value (off_ext)
    );

    operand_extend #(.IN_W(JMP_W), .XLEN(XLEN)) u_ext_jmp (
        .field (bus.jump_off),
        .zext  (bus.zext),
        .value (jmp_ext)
    );

`ifdef OPSTAGE_FWD_EN
    logic mem_fwd1;
    logic mem_fwd2;
    logic wb_fwd1;
    logic wb_fwd2;
    logic load_hit1;
    logic load_hit2;

    // Forward from MEM (non-load only) then WB; MEM is younger so it wins
    always_comb begin
        mem_fwd1 = bus.mem_wr_en && !bus.mem_is_load && (bus.mem_wr_addr == bus.rs1_addr);
        mem_fwd2 = bus.mem_wr_en && !bus.mem_is_load && (bus.mem_wr_addr == bus.rs2_addr);
        wb_fwd1  = bus.wb_wr_en && (bus.wb_wr_addr == bus.rs1_addr);
        wb_fwd2  = bus.wb_wr_en && (bus.wb_wr_addr == bus.rs2_addr);

        if (bus.rs1_addr == '0)  rs1_val = '0;
        else if (mem_fwd1)       rs1_val = bus.mem_wr_data;
        else if (wb_fwd1)        rs1_val = bus.wb_wr_data;
        else                     rs1_val = bus.read_data1;

        if (bus.rs2_addr == '0)  rs2_val = '0;
        else if (mem_fwd2)       rs2_val = bus.mem_wr_data;
        else if (wb_fwd2)        rs2_val = bus.wb_wr_data;
        else                     rs2_val = bus.read_data2;
    end

    // A load in MEM has no data yet, so a dependent ID instruction must wait one cycle
    always_comb begin
        load_hit1 = bus.mem_wr_addr == bus.rs1_addr;
        load_hit2 = bus.use_rs2 && (bus.mem_wr_addr == bus.rs2_addr);
        hazard    = bus.in_valid && bus.mem_wr_en && bus.mem_is_load &&
                    (bus.mem_wr_addr != '0) && (load_hit1 || load_hit2);
    end
`else
    logic mem_hit;
    logic wb_hit;
    logic unused_fwd;

    // Operands come straight from the write-first register file
    always_comb begin
        rs1_val = bus.read_data1;
        rs2_val = bus.read_data2;
    end

    // Without bypass paths any pending write to a source register stalls ID
    always_comb begin
        mem_hit = bus.mem_wr_en && (bus.mem_wr_addr != '0) &&
                  ((bus.mem_wr_addr == bus.rs1_addr) ||
                   (bus.use_rs2 && (bus.mem_wr_addr == bus.rs2_addr)));
        wb_hit  = bus.wb_wr_en && (bus.wb_wr_addr != '0) &&
                  ((bus.wb_wr_addr == bus.rs1_addr) ||
                   (bus.use_rs2 && (bus.wb_wr_addr == bus.rs2_addr)));
        hazard  = bus.in_valid && (mem_hit || wb_hit);
    end

    assign unused_fwd = ^{bus.mem_is_load, bus.mem_wr_data, bus.wb_wr_data};
`endif

    // Operand-2 source: forwarded rs2 or one of the extended instruction fields
    always_comb begin
        case (src_sel_e'(bus.src_sel))
            SRC_IMM: op2_val = imm_ext;
            SRC_OFF: op2_val = off_ext;
            SRC_JMP: op2_val = jmp_ext;
            default: op2_val = rs2_val;
        endcase
    end

    // Accept from ID when not stalled and the output slot is free or being drained
    always_comb begin
        in_ready = !hazard && (!out_valid_q || bus.out_ready);
        transfer = bus.in_valid && in_ready;
    end

    // One-entry pipeline register towards the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            input1_q     <= '0;
            input2_q     <= '0;
            store_data_q <= '0;
        end else if (transfer) begin
            out_valid_q  <= 1'b1;
            input1_q     <= rs1_val;
            input2_q     <= op2_val;
            store_data_q <= rs2_val;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.hazard     = hazard;
    assign bus.out_valid  = out_valid_q;
    assign bus.input1     = input1_q;
    assign bus.input2     = input2_q;
    assign bus.store_data = store_data_q;

endmodule
